mips_exec_unit: RTL and testbench

//   Execute-stage arithmetic for the single-cycle MIPS core: ALU-control decode
//   (aluOp + funct -> 4-bit operation), the 32-bit ALU with zero flag, and the
//   two PC adders (PC+4 and branch target). Datapath outputs are combinational
//   so the core closes in one cycle. clk/rst clock only a sticky overflow flag.

---
 rtl/mips_exec_unit.sv | 94 +++++++++
 tb/tb_mips_exec_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mips_exec_unit.sv
// Execute stage of the single-cycle MIPS core: ALU-control decode, 32-bit ALU,
// PC+4 and branch-target adders, plus a sticky signed-overflow flag.
module mips_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [15:0]      imm16,
  output logic [3:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic             ovf_sticky
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] sum, diff, br_off;
  logic signed [17:0] off18;
  logic ovf, ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    operation = OP_ADD;
    unique case (alu_op)
      2'b01: operation = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: operation = OP_ADD;
          6'b100010: operation = OP_SUB;
          6'b100100: operation = OP_AND;
          6'b100101: operation = OP_OR;
          6'b101010: operation = OP_SLT;
          6'b100111: operation = OP_NOR;
          default:   operation = OP_ADD;
        endcase
      end
      default: operation = OP_ADD;
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    case (operation)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: result = sum;
      OP_SUB: result = diff;
      // true signed compare; the sign of a-b is wrong when the subtract overflows
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  always_comb begin
    ovf = 1'b0;
    if (operation == OP_ADD)
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (operation == OP_SUB)
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  // word offset sign-extended to the datapath width
  assign off18         = {imm16, 2'b00};
  assign br_off        = WIDTH'(off18);
  assign pc_plus4      = pc + WIDTH'(4);
  assign branch_target = pc_plus4 + br_off;

  assign ovf_sticky_d = ovf_sticky_q | ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed-vector bench for mips_exec_unit with hand-computed expectations.
module tb_mips_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b, pc;
  logic [15:0] imm16;
  logic [3:0]  operation;
  logic [31:0] result, pc_plus4, branch_target;
  logic        zero, ovf_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  mips_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .pc(pc), .imm16(imm16), .operation(operation), .result(result),
    .zero(zero), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // apply a vector just after a falling edge, then settle
  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    alu_op = op; funct = fn; a = av; b = bv;
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_op = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
    pc = 32'd0; imm16 = 16'd0;
    #2;
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_comb_pc4", pc_plus4, 32'h4);
    @(negedge clk); rst = 1'b0;

    drive(2'b10, 6'b100010, 32'd7, 32'd7);
    chk("sub_op", {28'd0, operation}, 32'h6);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);

    drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    chk("slt_op", {28'd0, operation}, 32'h7);
    chk("slt_neg_lt", result, 32'd1);
    chk("slt_neg_zero", {31'd0, zero}, 32'd0);
    drive(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF);
    chk("slt_pos_gt", result, 32'd0);
    chk("slt_pos_zero", {31'd0, zero}, 32'd1);
    // a-b overflows here, so a sign-of-difference SLT would answer 0
    drive(2'b10, 6'b101010, 32'h80000000, 32'd1);
    chk("slt_ovf_case", result, 32'd1);

    drive(2'b10, 6'b100111, 32'h0F0F0000, 32'h000000F0);
    chk("nor_op", {28'd0, operation}, 32'hC);
    chk("nor_res", result, 32'hF0F0FF0F);

    drive(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("and_op", {28'd0, operation}, 32'h0);
    chk("and_res", result, 32'hF000F000);
    drive(2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("or_op", {28'd0, operation}, 32'h1);
    chk("or_res", result, 32'hFFF0FFF0);

    drive(2'b10, 6'b100000, 32'd5, 32'd3);
    chk("add_op", {28'd0, operation}, 32'h2);
    chk("add_res", result, 32'd8);
    drive(2'b10, 6'b000000, 32'd5, 32'd3);
    chk("dflt_funct_op", {28'd0, operation}, 32'h2);
    drive(2'b01, 6'b100100, 32'd10, 32'd3);
    chk("beq_op", {28'd0, operation}, 32'h6);
    chk("beq_res", result, 32'd7);
    drive(2'b11, 6'b100010, 32'd10, 32'd3);
    chk("op11_op", {28'd0, operation}, 32'h2);
    chk("op11_res", result, 32'd13);

    @(negedge clk); pc = 32'h00400000; imm16 = 16'hFFFF; #1;
    chk("pc4", pc_plus4, 32'h00400004);
    chk("bt_neg", branch_target, 32'h00400000);
    imm16 = 16'h0003; #1;
    chk("bt_pos", branch_target, 32'h00400010);
    pc = 32'hFFFFFFFC; #1;
    chk("pc4_wrap", pc_plus4, 32'h00000000);
    pc = 32'h00000000; imm16 = 16'h7FFF; #1;
    chk("bt_maxoff", branch_target, 32'h00020000);

    chk("sticky_clean", {31'd0, ovf_sticky}, 32'd0);

    drive(2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1);
    chk("add_wrap", result, 32'h80000000);
    @(posedge clk); #1;
    chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    drive(2'b00, 6'b000000, 32'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_hold", {31'd0, ovf_sticky}, 32'd1);

    @(negedge clk); rst = 1'b1; #1;
    chk("async_clr", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_res", result, 32'd2);
    @(negedge clk); rst = 1'b0;

    drive(2'b01, 6'b000000, 32'h80000000, 32'd1);
    chk("sub_wrap", result, 32'h7FFFFFFF);
    @(posedge clk); #1;
    chk("sticky_sub", {31'd0, ovf_sticky}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
